// File: rtl/instruction_fetch_pkg.sv
// Shared CPU constants for the fetch stage, decode and immediate generation.
// Also holds the fetch FSM state type and a word-alignment helper.
package instruction_fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h00000013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h00000000;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic {
        ST_RESET,
        ST_FETCH
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_fetch_buffer.sv
// Synchronous FIFO with push, pop and flush; head is read straight from storage.
// Storage resets to RESET_VALUE so the head shows a defined word while empty.
module fetch_buffer #(
    parameter int                WIDTH       = 32,
    parameter int                DEPTH       = 2,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = storage[rd_ptr];
    assign do_pop  = pop && !flush && !empty;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= RESET_VALUE;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                storage[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word requests, buffers tagged responses for decode
// and discards responses that were in flight when a redirect arrived.
//
//   state    | meaning
//   ST_RESET | first cycle after reset release, no requests
//   ST_FETCH | normal operation, permanent
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int          BUFFER_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_request,
    output logic [31:0] mem_address,
    input  logic        mem_ready,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    output logic        instruction_valid,
    input  logic        instruction_ready,
    output logic [31:0] instruction,
    output logic [31:0] instruction_pc
);

    localparam int CW = $clog2(BUFFER_DEPTH) + 1;

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [CW-1:0] drop;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          addr_empty;
    logic          addr_full;
    logic          buf_empty;
    logic          buf_full;
    logic [31:0]   resp_pc;
    logic [63:0]   buf_head;
    logic          accept;
    logic          resp;
    logic          resp_keep;
    logic          dec_pop;

    // In-flight plus buffered words never exceed the buffer depth, so a buffered
    // response always has room and back-pressure stalls requests instead of data.
    assign occupancy   = {1'b0, in_flight} + {1'b0, count};
    assign mem_request = (state == ST_FETCH) && !redirect && !addr_full &&
                         (occupancy < (CW+1)'(BUFFER_DEPTH));
    assign mem_address = pc;
    assign accept      = mem_request && mem_ready;
    assign resp        = mem_valid && !addr_empty;
    assign dec_pop     = instruction_valid && instruction_ready && !redirect;
    assign resp_keep   = resp && (drop == '0) && !redirect && (!buf_full || dec_pop);

    assign instruction_valid = !buf_empty;
    assign instruction       = buf_head[31:0];
    assign instruction_pc    = buf_head[63:32];

    fetch_buffer #(
        .WIDTH       (32),
        .DEPTH       (BUFFER_DEPTH),
        .RESET_VALUE (RESET_PC)
    ) u_addr_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (accept),
        .push_data (pc),
        .pop       (resp),
        .flush     (1'b0),
        .head      (resp_pc),
        .count     (in_flight),
        .empty     (addr_empty),
        .full      (addr_full)
    );

    fetch_buffer #(
        .WIDTH       (64),
        .DEPTH       (BUFFER_DEPTH),
        .RESET_VALUE ({RESET_PC, NOP})
    ) u_inst_buffer (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (resp_keep),
        .push_data ({resp_pc, mem_data}),
        .pop       (dec_pop),
        .flush     (redirect),
        .head      (buf_head),
        .count     (count),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RESET;
            pc    <= RESET_PC;
            drop  <= '0;
        end else begin
            case (state)
                ST_RESET: state <= ST_FETCH;
                default:  state <= ST_FETCH;
            endcase
            if (redirect) begin
                pc   <= word_align(redirect_pc);
                drop <= in_flight - CW'(resp);
            end else begin
                if (accept) begin
                    pc <= pc + 32'd4;
                end
                if (resp && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: cycle table with a hand-driven memory,
// then streaming sequences against a single-cycle memory model.
module tb_instruction_fetch;

    localparam logic [31:0] NOP_WORD = 32'h00000013;

    logic        clock;
    logic        reset_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_request;
    logic [31:0] mem_address;
    logic        mem_ready;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        instruction_valid;
    logic        instruction_ready;
    logic [31:0] instruction;
    logic [31:0] instruction_pc;

    logic        auto_mem;
    logic        man_valid;
    logic [31:0] man_data;
    logic        model_valid;
    logic [31:0] model_addr;

    logic        w_request;
    logic [31:0] w_address;
    logic        w_valid;
    logic        w_iv;
    logic [31:0] w_ins;
    logic [31:0] w_ipc;
    logic [31:0] wrap_log[$];

    int          checks;
    int          errors;
    int          delivered;
    logic        mon_en;
    logic [31:0] exp_pc;

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        mv;
        logic [31:0] md;
        logic        ir;
        logic        req;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ins;
        logic [31:0] ipc;
    } vec_t;

    vec_t vecs[25];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h00000000: return 32'h06002103;
            32'h00000100: return 32'hFFFFF037;
            default:      return {~a[15:0], a[15:0]};
        endcase
    endfunction

    function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic rdy,
                                input logic mv, input logic [31:0] md, input logic ir,
                                input logic req, input logic [31:0] addr, input logic iv,
                                input logic [31:0] ins, input logic [31:0] ipc);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.mv = mv; v.md = md; v.ir = ir;
        v.req = req; v.addr = addr; v.iv = iv; v.ins = ins; v.ipc = ipc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", name, act, exp);
        end
    endtask

    instruction_fetch #(.RESET_PC(32'h00000000), .BUFFER_DEPTH(2)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .mem_request       (mem_request),
        .mem_address       (mem_address),
        .mem_ready         (mem_ready),
        .mem_valid         (mem_valid),
        .mem_data          (mem_data),
        .instruction_valid (instruction_valid),
        .instruction_ready (instruction_ready),
        .instruction       (instruction),
        .instruction_pc    (instruction_pc)
    );

    instruction_fetch #(.RESET_PC(32'hFFFFFFF8), .BUFFER_DEPTH(2)) dut_w (
        .clock             (clock),
        .reset_n           (reset_n),
        .redirect          (1'b0),
        .redirect_pc       (32'h0),
        .mem_request       (w_request),
        .mem_address       (w_address),
        .mem_ready         (1'b1),
        .mem_valid         (w_valid),
        .mem_data          (NOP_WORD),
        .instruction_valid (w_iv),
        .instruction_ready (1'b1),
        .instruction       (w_ins),
        .instruction_pc    (w_ipc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_valid = auto_mem ? model_valid : man_valid;
    assign mem_data  = auto_mem ? mem_word(model_addr) : man_data;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            model_valid <= 1'b0;
            model_addr  <= 32'h0;
            w_valid     <= 1'b0;
        end else begin
            model_valid <= auto_mem && mem_request && mem_ready;
            model_addr  <= mem_address;
            w_valid     <= w_request;
        end
    end

    always @(negedge clock) begin
        if (reset_n && w_request && wrap_log.size() < 3) wrap_log.push_back(w_address);
    end

    always @(negedge clock) begin
        if (mon_en && instruction_valid && instruction_ready && !redirect) begin
            check("deliver_pc", instruction_pc, exp_pc);
            check("deliver_ins", instruction, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
    end

    initial begin
        checks = 0; errors = 0; delivered = 0; mon_en = 1'b0; exp_pc = 32'h0;
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; mem_ready = 1'b0;
        instruction_ready = 1'b0; auto_mem = 1'b0; man_valid = 1'b0; man_data = 32'h0;

        vecs[0]  = mk(0, 32'h0,   0, 0, 32'h0,        0, 0, 32'h000, 0, NOP_WORD,     32'h0);
        vecs[1]  = mk(0, 32'h0,   1, 0, 32'h0,        0, 1, 32'h000, 0, 32'h0,        32'h0);
        vecs[2]  = mk(0, 32'h0,   1, 1, 32'h06002103, 0, 1, 32'h004, 0, 32'h0,        32'h0);
        vecs[3]  = mk(0, 32'h0,   1, 0, 32'h0,        0, 0, 32'h008, 1, 32'h06002103, 32'h000);
        vecs[4]  = mk(0, 32'h0,   1, 1, 32'h11111111, 0, 0, 32'h008, 1, 32'h06002103, 32'h000);
        vecs[5]  = mk(0, 32'h0,   1, 0, 32'h0,        0, 0, 32'h008, 1, 32'h06002103, 32'h000);
        vecs[6]  = mk(0, 32'h0,   1, 0, 32'h0,        1, 0, 32'h008, 1, 32'h06002103, 32'h000);
        vecs[7]  = mk(0, 32'h0,   0, 0, 32'h0,        0, 1, 32'h008, 1, 32'h11111111, 32'h004);
        vecs[8]  = mk(0, 32'h0,   0, 0, 32'h0,        0, 1, 32'h008, 1, 32'h11111111, 32'h004);
        vecs[9]  = mk(0, 32'h0,   1, 0, 32'h0,        1, 1, 32'h008, 1, 32'h11111111, 32'h004);
        vecs[10] = mk(0, 32'h0,   1, 0, 32'h0,        0, 1, 32'h00C, 0, 32'h0,        32'h0);
        vecs[11] = mk(1, 32'h103, 1, 0, 32'h0,        0, 0, 32'h010, 0, 32'h0,        32'h0);
        vecs[12] = mk(0, 32'h0,   1, 1, 32'hDEADBEEF, 0, 0, 32'h100, 0, 32'h0,        32'h0);
        vecs[13] = mk(0, 32'h0,   1, 1, 32'hDEADBEEF, 0, 1, 32'h100, 0, 32'h0,        32'h0);
        vecs[14] = mk(0, 32'h0,   0, 1, 32'hFFFFF037, 0, 1, 32'h104, 0, 32'h0,        32'h0);
        vecs[15] = mk(0, 32'h0,   0, 0, 32'h0,        0, 1, 32'h104, 1, 32'hFFFFF037, 32'h100);
        vecs[16] = mk(0, 32'h0,   1, 0, 32'h0,        0, 1, 32'h104, 1, 32'hFFFFF037, 32'h100);
        vecs[17] = mk(1, 32'h200, 0, 1, 32'h22222222, 1, 0, 32'h108, 1, 32'hFFFFF037, 32'h100);
        vecs[18] = mk(0, 32'h0,   1, 0, 32'h0,        0, 1, 32'h200, 0, 32'h0,        32'h0);
        vecs[19] = mk(0, 32'h0,   0, 1, 32'h33333333, 0, 1, 32'h204, 0, 32'h0,        32'h0);
        vecs[20] = mk(0, 32'h0,   0, 0, 32'h0,        0, 1, 32'h204, 1, 32'h33333333, 32'h200);
        vecs[21] = mk(0, 32'h0,   0, 1, 32'h44444444, 0, 1, 32'h204, 1, 32'h33333333, 32'h200);
        vecs[22] = mk(0, 32'h0,   0, 0, 32'h0,        0, 1, 32'h204, 1, 32'h33333333, 32'h200);
        vecs[23] = mk(1, 32'h301, 1, 0, 32'h0,        0, 0, 32'h204, 1, 32'h33333333, 32'h200);
        vecs[24] = mk(0, 32'h0,   0, 0, 32'h0,        0, 1, 32'h300, 0, 32'h0,        32'h0);

        // Held in reset
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_request", {31'b0, mem_request}, 32'h0);
        check("rst_address", mem_address, 32'h0);
        check("rst_valid", {31'b0, instruction_valid}, 32'h0);
        check("rst_instruction", instruction, NOP_WORD);
        check("rst_pc", instruction_pc, 32'h0);

        // Cycle table with hand-driven memory
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            redirect = vecs[i].rd; redirect_pc = vecs[i].rpc; mem_ready = vecs[i].rdy;
            man_valid = vecs[i].mv; man_data = vecs[i].md; instruction_ready = vecs[i].ir;
            @(negedge clock);
            check($sformatf("vec%0d_request", i), {31'b0, mem_request}, {31'b0, vecs[i].req});
            check($sformatf("vec%0d_address", i), mem_address, vecs[i].addr);
            check($sformatf("vec%0d_valid", i), {31'b0, instruction_valid}, {31'b0, vecs[i].iv});
            if (vecs[i].iv) begin
                check($sformatf("vec%0d_instruction", i), instruction, vecs[i].ins);
                check($sformatf("vec%0d_pc", i), instruction_pc, vecs[i].ipc);
            end
            @(posedge clock); #1;
        end

        // Restart with single-cycle memory
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; man_valid = 1'b0; man_data = 32'h0;
        auto_mem = 1'b1; mem_ready = 1'b1; instruction_ready = 1'b1;
        @(posedge clock); #1;
        reset_n = 1'b1; exp_pc = 32'h0; delivered = 0; mon_en = 1'b1;
        @(negedge clock);
        check("boot_c0_request", {31'b0, mem_request}, 32'h0);
        @(posedge clock); #1; @(negedge clock);
        check("boot_c1_request", {31'b0, mem_request}, 32'h1);
        check("boot_c1_address", mem_address, 32'h0);
        @(posedge clock); #1; @(negedge clock);
        check("boot_c2_request", {31'b0, mem_request}, 32'h1);
        check("boot_c2_address", mem_address, 32'h4);
        check("boot_c2_valid", {31'b0, instruction_valid}, 32'h0);
        @(posedge clock); #1; @(negedge clock);
        check("boot_c3_valid", {31'b0, instruction_valid}, 32'h1);
        check("boot_c3_instruction", instruction, 32'h06002103);
        check("boot_c3_pc", instruction_pc, 32'h0);
        check("boot_c3_request", {31'b0, mem_request}, 32'h0);
        @(posedge clock); #1; @(negedge clock);
        check("boot_c4_request", {31'b0, mem_request}, 32'h1);
        check("boot_c4_address", mem_address, 32'h8);

        // Random decode back-pressure, then hard stall and resume
        for (int i = 0; i < 60; i++) begin
            @(posedge clock); #1;
            instruction_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clock); #1;
        instruction_ready = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        check("stall_request", {31'b0, mem_request}, 32'h0);
        check("stall_valid", {31'b0, instruction_valid}, 32'h1);
        @(posedge clock); #1;
        instruction_ready = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        instruction_ready = 1'b0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        check("full_request", {31'b0, mem_request}, 32'h0);
        check("full_valid", {31'b0, instruction_valid}, 32'h1);
        check("delivered_enough", {31'b0, (delivered >= 8)}, 32'h1);
        mon_en = 1'b0;

        // Reset asserted mid-cycle with two words buffered
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_request", {31'b0, mem_request}, 32'h0);
        check("midrst_address", mem_address, 32'h0);
        check("midrst_valid", {31'b0, instruction_valid}, 32'h0);
        check("midrst_instruction", instruction, NOP_WORD);
        check("midrst_pc", instruction_pc, 32'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("restart_c0_request", {31'b0, mem_request}, 32'h0);
        @(posedge clock); #1; @(negedge clock);
        check("restart_c1_request", {31'b0, mem_request}, 32'h1);
        check("restart_c1_address", mem_address, 32'h0);

        // PC wrap on the second instance
        check("wrap_count", wrap_log.size(), 32'd3);
        if (wrap_log.size() >= 3) begin
            check("wrap_0", wrap_log[0], 32'hFFFFFFF8);
            check("wrap_1", wrap_log[1], 32'hFFFFFFFC);
            check("wrap_2", wrap_log[2], 32'h00000000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
